alu_issue_unit: RTL

//  Initiator side of the combinational ALU interface: accepts operation requests over a

---
 rtl/alu_issue_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Request/response wrapper around a purely combinational ALU.
// A single issue register feeds the ALU ports, and each ALU result is captured
// into a small response FIFO. The requester sees a valid/ready request port and
// the consumer sees a valid/ready response port.
module alu_issue_unit #(
  parameter int RSP_DEPTH   = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_op1,
  input  logic [31:0]            req_op2,
  input  logic [3:0]             req_alu_op,
  output logic [31:0]            alu_op1,
  output logic [31:0]            alu_op2,
  output logic [3:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic                   r_issValid;
  logic [31:0]            r_issOp1;
  logic [31:0]            r_issOp2;
  logic [3:0]             r_issOp;

  logic [31:0]            r_fifoResult [RSP_DEPTH];
  logic                   r_fifoZero   [RSP_DEPTH];
  logic [PTR_W-1:0]       r_rdPtr;
  logic [PTR_W-1:0]       r_wrPtr;
  logic [CNT_W-1:0]       r_count;
  logic [COUNT_WIDTH-1:0] r_opCount;

  logic                   w_rspPop;
  logic                   w_fifoHasRoom;
  logic                   w_issFire;
  logic                   w_reqAccept;

  // Handshake decisions: a pop in the same cycle frees a slot for the issue register,
  // so a full FIFO still allows one op per clock while the consumer keeps up.
  always_comb begin
    w_rspPop      = rsp_valid && rsp_ready;
    w_fifoHasRoom = (r_count < DEPTH_C) || w_rspPop;
    w_issFire     = r_issValid && w_fifoHasRoom;
    req_ready     = !r_issValid || w_issFire;
    w_reqAccept   = req_valid && req_ready;
  end

  // ALU drive is forced to a neutral ADD of zeros when idle so no stale operands leak out.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALUOP_ADD;
    if (r_issValid) begin
      alu_op1  = r_issOp1;
      alu_op2  = r_issOp2;
      alu_ctrl = r_issOp;
    end
  end

  // Response head is shown only while valid; otherwise the outputs read as zero.
  always_comb begin
    rsp_valid  = (r_count != '0);
    rsp_result = '0;
    rsp_zero   = 1'b0;
    if (rsp_valid) begin
      rsp_result = r_fifoResult[r_rdPtr];
      rsp_zero   = r_fifoZero[r_rdPtr];
    end
    op_count = r_opCount;
  end

  // Issue register: load on accept, otherwise empty out once its result has been captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issValid <= 1'b0;
      r_issOp1   <= '0;
      r_issOp2   <= '0;
      r_issOp    <= ALUOP_ADD;
    end else if (w_reqAccept) begin
      r_issValid <= 1'b1;
      r_issOp1   <= req_op1;
      r_issOp2   <= req_op2;
      r_issOp    <= req_alu_op;
    end else if (w_issFire) begin
      r_issValid <= 1'b0;
    end
  end

  // Response FIFO storage and pointers; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifoResult[i] <= '0;
        r_fifoZero[i]   <= 1'b0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_issFire) begin
        r_fifoResult[r_wrPtr] <= alu_result;
        r_fifoZero[r_wrPtr]   <= (alu_result == 32'd0);
        r_wrPtr               <= r_wrPtr + PTR_W'(1);
      end
      if (w_rspPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_issFire && !w_rspPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_issFire && w_rspPop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Completed-operation counter, wraps silently at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opCount <= '0;
    end else if (w_rspPop) begin
      r_opCount <= r_opCount + COUNT_WIDTH'(1);
    end
  end

endmodule
